// File: rtl/iir_fmt_pkg.sv
// Shared constants and helpers for the IIR output formatter and its FIFO.
// Holds the rounding constant, the saturation bounds and the event-counter ceiling.
package iir_fmt_pkg;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Half an output LSB, expressed at the input scaling.
  function automatic logic [127:0] rnd_const(input int frac_shift);
    return (frac_shift > 0) ? (128'd1 << (frac_shift - 1)) : 128'd0;
  endfunction

  function automatic logic signed [127:0] out_max(input int out_width);
    return (128'sd1 <<< (out_width - 1)) - 128'sd1;
  endfunction

  function automatic logic signed [127:0] out_min(input int out_width);
    return -(128'sd1 <<< (out_width - 1));
  endfunction

endpackage

// File: rtl/iir_fmt_fifo.sv
// Synchronous FIFO whose head entry sits in a register, so data/valid
// leave the block with no read-path logic in front of them.
module iir_fmt_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             data,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [CNT_W-1:0] cnt_next;
  logic             pop_en;
  logic             push_en;

  assign valid    = (count != '0);
  assign pop_en   = pop & valid;
  assign push_en  = push & ((count != CNT_W'(DEPTH)) | pop_en);
  assign rd_next  = rd_ptr + PTR_W'(pop_en);
  assign cnt_next = count + CNT_W'(push_en) - CNT_W'(pop_en);

  // NOTE: sequential state uses <= so every register samples pre-edge values
  // regardless of statement order inside the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      data   <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_next;
      count  <= cnt_next;
      // Head follows the next entry; a push landing on it bypasses storage.
      if (cnt_next != '0)
        data <= (push_en && (wr_ptr == rd_next)) ? push_data : mem[rd_next];
    end
  end

  // NOTE: storage is never reset; validity is tracked by count, and leaving
  // the array out of reset lets it map to plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/iir_output_formatter.sv
// Requantizes the IIR filter's full-precision output, saturates, and buffers it.
// Build macro IIR_FMT_ROUND_EN selects round-half-up; otherwise truncation.
module iir_output_formatter
  import iir_fmt_pkg::*;
#(
  parameter int IN_WIDTH   = 64,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_SHIFT = 30,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 sat_clr,
  output logic                 sat_flag,
  output logic [15:0]          overflow_count
);

  localparam int R_W   = IN_WIDTH + 1 - FRAC_SHIFT;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic signed [R_W-1:0]  R_MAX  = R_W'(out_max(OUT_WIDTH));
  localparam logic signed [R_W-1:0]  R_MIN  = R_W'(out_min(OUT_WIDTH));
  localparam logic [OUT_WIDTH-1:0]   SAT_HI = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0]   SAT_LO = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic                  accept;
  logic signed [R_W-1:0] r_next;
  logic                  unused_frac;

  logic                  s1_valid;
  logic signed [R_W-1:0] s1_r;
  logic                  s2_valid;
  logic [OUT_WIDTH-1:0]  s2_data;

  logic [OUT_WIDTH-1:0]  sat_data;
  logic                  sat_hit;

  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        in_flight;

  assign accept = in_valid & in_ready;

  // Stage 1: arithmetic shift is a slice of the one-bit-wider sum.
`ifdef IIR_FMT_ROUND_EN
  localparam logic [IN_WIDTH:0] RND = (IN_WIDTH+1)'(rnd_const(FRAC_SHIFT));
  logic [IN_WIDTH:0] sum;
  assign sum         = {in_data[IN_WIDTH-1], in_data} + RND;
  assign r_next      = sum[IN_WIDTH:FRAC_SHIFT];
  assign unused_frac = ^sum[FRAC_SHIFT-1:0];
`else
  assign r_next      = {in_data[IN_WIDTH-1], in_data[IN_WIDTH-1:FRAC_SHIFT]};
  assign unused_frac = ^in_data[FRAC_SHIFT-1:0];
`endif

  // NOTE: every output of this block gets a default first, so no path
  // through the branches can leave a value unassigned and infer a latch.
  always_comb begin
    sat_data = s1_r[OUT_WIDTH-1:0];
    sat_hit  = 1'b0;
    if (s1_r > R_MAX) begin
      sat_data = SAT_HI;
      sat_hit  = s1_valid;
    end else if (s1_r < R_MIN) begin
      sat_data = SAT_LO;
      sat_hit  = s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
    end
  end

  // Datapath registers are qualified by the valids above and need no reset.
  always_ff @(posedge clk) begin
    if (accept)   s1_r    <= r_next;
    if (s1_valid) s2_data <= sat_data;
  end

  // A saturation in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag       <= 1'b0;
      overflow_count <= '0;
    end else begin
      if (sat_hit)      sat_flag <= 1'b1;
      else if (sat_clr) sat_flag <= 1'b0;
      if (sat_hit && (overflow_count != CNT_MAX))
        overflow_count <= overflow_count + 16'd1;
    end
  end

  // Credit check counts in-flight pipeline samples so the FIFO can never overflow.
  assign in_flight = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(s1_valid)
                   + (CNT_W+1)'(s2_valid);
  assign in_ready  = (in_flight < (CNT_W+1)'(FIFO_DEPTH));

  iir_fmt_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s2_valid),
    .push_data (s2_data),
    .pop       (out_valid & out_ready),
    .data      (out_data),
    .valid     (out_valid),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_iir_output_formatter.sv
// Directed bench for iir_output_formatter: reset, rounding, saturation,
// back-pressure, mid-stream reset and counter clamping.
module tb_iir_output_formatter;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        sat_clr;
  logic        sat_flag;
  logic [15:0] overflow_count;

  int checks = 0;
  int errors = 0;

  iir_output_formatter dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .sat_clr        (sat_clr),
    .sat_flag       (sat_flag),
    .overflow_count (overflow_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] q30(input longint v);
    return 64'(v) << 30;
  endfunction

  initial begin
    int  acc;
    int  cyc;
    logic was;
    logic [15:0] half_pos;
    logic [15:0] half_neg;

`ifdef IIR_FMT_ROUND_EN
    half_pos = 16'h0001;
    half_neg = 16'h0000;
`else
    half_pos = 16'h0000;
    half_neg = 16'hFFFF;
`endif

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; sat_clr = 1'b0;
    tick(); tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_sat_flag", 64'(sat_flag), 64'd0);
    check("rst_ovf_count", 64'(overflow_count), 64'd0);
    rst = 1'b0;

    // 5.0 through an empty pipeline: visible right after E0+2.
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 64'h0000_0001_4000_0000;
    tick();
    in_valid = 1'b0;
    check("t1_valid_e0", 64'(out_valid), 64'd0);
    tick();
    check("t1_valid_e1", 64'(out_valid), 64'd0);
    tick();
    check("t1_valid_e2", 64'(out_valid), 64'd1);
    check("t1_data", 64'(out_data), 64'h0005);
    check("t1_sat_flag", 64'(sat_flag), 64'd0);
    tick();
    check("t1_empty_valid", 64'(out_valid), 64'd0);
    check("t1_empty_hold", 64'(out_data), 64'h0005);

    // +0.5 and -0.5 back to back.
    in_valid = 1'b1; in_data = 64'h0000_0000_2000_0000;
    tick();
    in_data = 64'hFFFF_FFFF_E000_0000;
    tick();
    in_valid = 1'b0;
    tick();
    check("t2_pos_valid", 64'(out_valid), 64'd1);
    check("t2_pos_half", 64'(out_data), 64'(half_pos));
    tick();
    check("t2_neg_valid", 64'(out_valid), 64'd1);
    check("t2_neg_half", 64'(out_data), 64'(half_neg));
    tick();
    check("t2_drained", 64'(out_valid), 64'd0);

    // Saturation in both directions, then a clear.
    in_valid = 1'b1; in_data = q30(40000);
    tick();
    in_data = q30(-40000);
    tick();
    in_valid = 1'b0;
    tick();
    check("t3_sat_hi", 64'(out_data), 64'h7FFF);
    check("t3_flag", 64'(sat_flag), 64'd1);
    tick();
    check("t3_sat_lo", 64'(out_data), 64'h8000);
    check("t3_count", 64'(overflow_count), 64'd2);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    check("t3_flag_cleared", 64'(sat_flag), 64'd0);
    check("t3_count_kept", 64'(overflow_count), 64'd2);

    // Clear coinciding with a saturation: set wins.
    in_valid = 1'b1; in_data = q30(40000);
    tick();
    in_valid = 1'b0; sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    check("set_wins_flag", 64'(sat_flag), 64'd1);
    check("set_wins_count", 64'(overflow_count), 64'd3);
    tick();
    check("set_wins_data", 64'(out_data), 64'h7FFF);
    tick();

    // Back-pressure: exactly FIFO_DEPTH samples accepted.
    out_ready = 1'b0; in_valid = 1'b1; acc = 0;
    for (int i = 0; i < 8; i++) begin
      in_data = q30(longint'(acc + 1));
      was = in_ready;
      tick();
      if (was) acc++;
    end
    in_valid = 1'b0;
    check("t4_accepted", 64'(acc), 64'd4);
    check("t4_in_ready_low", 64'(in_ready), 64'd0);
    check("t4_head", 64'(out_data), 64'h0001);
    out_ready = 1'b1;
    tick();
    check("t4_credit_back", 64'(in_ready), 64'd1);
    check("t4_second", 64'(out_data), 64'h0002);
    tick();
    check("t4_third", 64'(out_data), 64'h0003);
    tick();
    check("t4_fourth", 64'(out_data), 64'h0004);
    tick();
    check("t4_drained", 64'(out_valid), 64'd0);

    // Reset with three buffered samples.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = q30(7); tick();
    in_data = q30(8); tick();
    in_data = q30(9); tick();
    in_valid = 1'b0;
    tick(); tick();
    check("t5_buffered_valid", 64'(out_valid), 64'd1);
    check("t5_pre_count", 64'(overflow_count), 64'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_valid_cleared", 64'(out_valid), 64'd0);
    check("t5_in_ready", 64'(in_ready), 64'd1);
    check("t5_count_cleared", 64'(overflow_count), 64'd0);
    check("t5_flag_cleared", 64'(sat_flag), 64'd0);
    out_ready = 1'b1; in_valid = 1'b1; in_data = q30(11);
    tick();
    in_valid = 1'b0;
    check("t5_lat_e0", 64'(out_valid), 64'd0);
    tick();
    check("t5_lat_e1", 64'(out_valid), 64'd0);
    tick();
    check("t5_lat_e2", 64'(out_valid), 64'd1);
    check("t5_data", 64'(out_data), 64'h000B);
    tick();

    // 65540 saturating samples: counter clamps at 0xFFFF.
    in_valid = 1'b1; in_data = q30(40000); acc = 0; cyc = 0;
    while (acc < 65540 && cyc < 70000) begin
      was = in_ready;
      tick();
      if (was) acc++;
      cyc++;
    end
    in_valid = 1'b0;
    check("t6_accepted", 64'(acc), 64'd65540);
    tick(); tick(); tick(); tick();
    check("t6_count_max", 64'(overflow_count), 64'hFFFF);
    check("t6_flag", 64'(sat_flag), 64'd1);
    check("t6_last_data", 64'(out_data), 64'h7FFF);
    tick(); tick(); tick();
    check("t6_count_hold", 64'(overflow_count), 64'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
